pc_unit: RTL and testbench

Registered program counter with a return-address stack (RAS) and a run/halt state machine. The next PC is selected from sequential increment, absolute or relative branch, call, and return. Address width, instruction size, stack depth and reset vector are parameters. The block sits at the head of the fetch stage: `pc_out` drives instruction-memory addressing and `pc_next` is available for prefetch.

---
 rtl/pc_unit.sv | 185 ++++++++++++++++++
 tb/tb_pc_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: registered program counter with a circular return-address stack
// and a run/halt state machine. pc_out addresses instruction memory and
// pc_next exposes the value pc_out takes at the next rising edge.
module pc_unit #(
    parameter int                         INST_ADDR_WIDTH   = 16,
    parameter int                         NUM_BYTES_IN_INST = 2,
    parameter int                         RAS_DEPTH         = 4,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_ADDR        = {INST_ADDR_WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       halt,
    input  logic                       resume,
    input  logic                       stall,
    input  logic                       branch,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       branch_rel,
    input  logic [INST_ADDR_WIDTH-1:0] branch_addr,
    output logic [INST_ADDR_WIDTH-1:0] pc_out,
    output logic [INST_ADDR_WIDTH-1:0] pc_next,
    output logic                       halted,
    output logic                       ras_empty,
    output logic                       ras_full,
    output logic                       ras_overflow,
    output logic                       ras_underflow
);

    localparam int W     = INST_ADDR_WIDTH;
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [W-1:0]     INC       = W'(NUM_BYTES_IN_INST);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       pc_q, pc_d;
    logic [PTR_W-1:0]   top_q, top_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;

    // Stack storage; contents are deliberately left unreset.
    logic [W-1:0]       ras_mem [RAS_DEPTH];

    logic [W-1:0]       seq_s;
    logic [W-1:0]       tgt_s;
    logic [W-1:0]       top_entry_s;
    logic [PTR_W-1:0]   top_inc_s;
    logic               wr_en_s;
    logic [PTR_W-1:0]   wr_idx_s;

    assign seq_s       = pc_q + INC;
    assign tgt_s       = branch_rel ? (pc_q + branch_addr) : branch_addr;
    assign top_entry_s = ras_mem[top_q];
    assign top_inc_s   = top_q + PTR_ONE;

    assign empty_d = (cnt_d == CNT_ZERO);
    assign full_d  = (cnt_d == CNT_MAX);

    // Next-state selection: reset, halt/resume, then the RUN priority chain.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        top_d    = top_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        wr_en_s  = 1'b0;
        wr_idx_s = top_q;
        if (!rst_n) begin
            state_d = ST_RUN;
            pc_d    = RESET_ADDR;
            top_d   = PTR_ZERO;
            cnt_d   = CNT_ZERO;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_HALTED: begin
                    if (!halt && resume) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HALTED;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else if (stall) begin
                        pc_d = pc_q;
                    end else if (call && ret) begin
                        // Tail call: replace the top entry, or push when empty.
                        pc_d    = tgt_s;
                        wr_en_s = 1'b1;
                        if (cnt_q == CNT_ZERO) begin
                            wr_idx_s = top_inc_s;
                            top_d    = top_inc_s;
                            cnt_d    = CNT_ONE;
                        end else begin
                            wr_idx_s = top_q;
                        end
                    end else if (ret) begin
                        if (cnt_q != CNT_ZERO) begin
                            pc_d  = top_entry_s;
                            top_d = top_q - PTR_ONE;
                            cnt_d = cnt_q - CNT_ONE;
                        end else begin
                            pc_d  = seq_s;
                            unf_d = 1'b1;
                        end
                    end else if (call) begin
                        // When full the push lands on the oldest entry.
                        pc_d     = tgt_s;
                        wr_en_s  = 1'b1;
                        wr_idx_s = top_inc_s;
                        top_d    = top_inc_s;
                        if (cnt_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else if (branch) begin
                        pc_d = tgt_s;
                    end else begin
                        pc_d = seq_s;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State, PC, stack pointer/count and status flags with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_ADDR;
            top_q   <= PTR_ZERO;
            cnt_q   <= CNT_ZERO;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    // Return-address storage write port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ras_mem[wr_idx_s] <= seq_s;
        end
    end

    assign pc_out        = pc_q;
    assign pc_next       = pc_d;
    assign halted        = (state_q == ST_HALTED);
    assign ras_empty     = empty_q;
    assign ras_full      = full_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed test-plan steps followed by random control traffic,
// all checked against a queue-based behavioural model of the PC/RAS.
module tb_pc_unit;

    localparam int          DEPTH = 4;
    localparam int          INC   = 2;
    localparam logic [15:0] RST_A = 16'h0100;

    logic        clk;
    logic        rst_n, halt, resume, stall, branch, call, ret, branch_rel;
    logic [15:0] branch_addr;
    logic [15:0] pc_out, pc_next;
    logic        halted, ras_empty, ras_full, ras_overflow, ras_underflow;

    pc_unit #(
        .INST_ADDR_WIDTH  (16),
        .NUM_BYTES_IN_INST(INC),
        .RAS_DEPTH        (DEPTH),
        .RESET_ADDR       (RST_A)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .halt         (halt),
        .resume       (resume),
        .stall        (stall),
        .branch       (branch),
        .call         (call),
        .ret          (ret),
        .branch_rel   (branch_rel),
        .branch_addr  (branch_addr),
        .pc_out       (pc_out),
        .pc_next      (pc_next),
        .halted       (halted),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: current and next-edge state.
    logic [15:0] m_pc;
    bit          m_halted, m_ovf, m_unf;
    logic [15:0] m_q[$];
    logic [15:0] n_pc;
    bit          n_halted, n_ovf, n_unf;
    logic [15:0] n_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_calc();
        logic [15:0] seq, tgt;
        n_pc = m_pc; n_halted = m_halted; n_q = m_q; n_ovf = m_ovf; n_unf = m_unf;
        seq = m_pc + 16'(INC);
        tgt = branch_rel ? 16'(m_pc + branch_addr) : branch_addr;
        if (!rst_n) begin
            n_pc = RST_A; n_halted = 1'b0; n_q.delete(); n_ovf = 1'b0; n_unf = 1'b0;
        end else if (m_halted) begin
            if (resume && !halt) n_halted = 1'b0;
        end else if (halt) begin
            n_halted = 1'b1;
        end else if (stall) begin
            n_pc = m_pc;
        end else if (call && ret) begin
            if (n_q.size() == 0) n_q.push_back(seq);
            else n_q[n_q.size()-1] = seq;
            n_pc = tgt;
        end else if (ret) begin
            if (n_q.size() > 0) n_pc = n_q.pop_back();
            else begin n_pc = seq; n_unf = 1'b1; end
        end else if (call) begin
            if (n_q.size() == DEPTH) begin
                void'(n_q.pop_front());
                n_ovf = 1'b1;
            end
            n_q.push_back(seq);
            n_pc = tgt;
        end else if (branch) begin
            n_pc = tgt;
        end else begin
            n_pc = seq;
        end
    endtask

    // One clock cycle: drive, check pc_next, clock, check registered outputs.
    task automatic step(input bit r_n, input bit h, input bit rs, input bit st,
                        input bit br, input bit ca, input bit rt, input bit rel,
                        input logic [15:0] ad, input string tag);
        rst_n = r_n; halt = h; resume = rs; stall = st; branch = br;
        call = ca; ret = rt; branch_rel = rel; branch_addr = ad;
        #1;
        model_calc();
        chk({tag, ":pc_next"}, pc_next, n_pc);
        @(posedge clk);
        #1;
        m_pc = n_pc; m_halted = n_halted; m_q = n_q; m_ovf = n_ovf; m_unf = n_unf;
        chk({tag, ":pc_out"}, pc_out, m_pc);
        chk({tag, ":halted"}, halted, m_halted);
        chk({tag, ":ras_empty"}, ras_empty, m_q.size() == 0);
        chk({tag, ":ras_full"}, ras_full, m_q.size() == DEPTH);
        chk({tag, ":ras_overflow"}, ras_overflow, m_ovf);
        chk({tag, ":ras_underflow"}, ras_underflow, m_unf);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, tag);
    endtask
    task automatic jmp(input logic [15:0] a, input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, tag);
    endtask
    task automatic call_to(input logic [15:0] a, input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, tag);
    endtask
    task automatic do_ret(input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, tag);
    endtask
    task automatic do_reset(input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, tag);
    endtask

    initial begin
        logic [15:0] held;
        rst_n = 1'b0; halt = 1'b0; resume = 1'b0; stall = 1'b0; branch = 1'b0;
        call = 1'b0; ret = 1'b0; branch_rel = 1'b0; branch_addr = 16'h0000;
        m_pc = RST_A; m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_q.delete();

        // Reset and sequential fetch.
        do_reset("rst0");
        do_reset("rst1");
        chk("tp1_reset_pc", pc_out, 16'h0100);
        chk("tp1_reset_empty", ras_empty, 1'b1);
        idle("seq0"); chk("tp1_pc1", pc_out, 16'h0102);
        idle("seq1"); chk("tp1_pc2", pc_out, 16'h0104);
        idle("seq2"); chk("tp1_pc3", pc_out, 16'h0106);

        // Call and return.
        jmp(16'h0010, "to_0010");
        call_to(16'h0200, "call"); chk("tp2_call", pc_out, 16'h0200);
        idle("cr_i0"); chk("tp2_i0", pc_out, 16'h0202);
        idle("cr_i1"); chk("tp2_i1", pc_out, 16'h0204);
        do_ret("ret"); chk("tp2_ret", pc_out, 16'h0012);
        chk("tp2_empty", ras_empty, 1'b1);

        // Overflow and underflow.
        jmp(16'h0000, "to_0000");
        for (int i = 0; i < 5; i++) begin
            call_to(16'h0000, "ovf_call");
            if (i == 3) begin
                chk("tp3_full4", ras_full, 1'b1);
                chk("tp3_noovf4", ras_overflow, 1'b0);
            end
        end
        chk("tp3_ovf5", ras_overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            do_ret("unf_ret");
            chk("tp3_ret_addr", pc_out, 16'h0002);
        end
        chk("tp3_nounf", ras_underflow, 1'b0);
        do_ret("unf_ret5");
        chk("tp3_ret5_seq", pc_out, 16'h0004);
        chk("tp3_unf", ras_underflow, 1'b1);

        // Relative branch with wrap.
        jmp(16'h0002, "to_0002");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFC, "rel");
        chk("tp4_rel", pc_out, 16'hFFFE);
        idle("wrap"); chk("tp4_wrap", pc_out, 16'h0000);

        // Priority and halt.
        jmp(16'h0300, "to_0300");
        held = pc_out;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0500, "stall_call");
        chk("tp5_stall_pc", pc_out, held);
        chk("tp5_stall_empty", ras_empty, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0600, "halt_branch");
        chk("tp5_halted", halted, 1'b1);
        chk("tp5_halt_pc", pc_out, held);
        for (int i = 0; i < 3; i++) begin
            jmp(16'h0700, "halted_branch");
            chk("tp5_frozen", pc_out, held);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "resume");
        chk("tp5_resumed", halted, 1'b0);
        chk("tp5_resume_pc", pc_out, held);
        idle("post_resume"); chk("tp5_inc", pc_out, held + 16'h0002);

        // Tail call and reset while halted.
        do_reset("rst2");
        jmp(16'h0040, "to_0040");
        call_to(16'h0080, "tc_call");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00A0, "tail");
        chk("tp6_tail_pc", pc_out, 16'h00A0);
        chk("tp6_tail_notempty", ras_empty, 1'b0);
        do_ret("tc_ret"); chk("tp6_tail_top", pc_out, 16'h0082);
        chk("tp6_tail_cnt1", ras_empty, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "halt2");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "rst_halted");
        chk("tp6_rst_halted", halted, 1'b0);
        chk("tp6_rst_pc", pc_out, RST_A);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit r_n, h, rs, st, br, ca, rt, rel;
            logic [15:0] ad;
            r_n = ($urandom_range(0, 99) != 0);
            h   = ($urandom_range(0, 99) < 5);
            rs  = ($urandom_range(0, 1) == 1);
            st  = ($urandom_range(0, 9) == 0);
            br  = ($urandom_range(0, 4) == 0);
            ca  = ($urandom_range(0, 3) == 0);
            rt  = ($urandom_range(0, 3) == 0);
            rel = ($urandom_range(0, 1) == 1);
            ad  = 16'($urandom);
            step(r_n, h, rs, st, br, ca, rt, rel, ad, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
